// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_pkg
// Purpose  : Shared definitions for the data-memory responder: FSM state
//            encoding, legal LATENCY bounds, counter width and a legality
//            helper used for the elaboration-time parameter check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

   // FSM state encoding (kept as plain constants for legacy tools)
   typedef logic [1:0] respState_t;
   localparam respState_t c_IDLE = 2'd0;
   localparam respState_t c_WAIT = 2'd1;
   localparam respState_t c_RESP = 2'd2;

   // Legal LATENCY range; the 4-bit counter caps the upper bound
   localparam int c_LATENCY_MIN = 1;
   localparam int c_LATENCY_MAX = 15;
   localparam int c_COUNT_W     = 4;

   function automatic bit latencyLegal(input int latency);
      return (latency >= c_LATENCY_MIN) && (latency <= c_LATENCY_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_mem.sv
`default_nettype none
// ============================================================================
// Module   : mem_word_array
// Purpose  : Word-addressed storage, 2^a words of n bits. Synchronous write
//            with enable, combinational read. Contents are never reset.
// Ports    : clk         - write clock
//            writeEnable - write the addressed word on this rising edge
//            index       - word index shared by read and write
//            writeData   - data written when writeEnable is high
//            readData    - combinational contents of the indexed word
// Revision : 1.0 - initial release
// ============================================================================
module mem_word_array #(
   parameter int n = 32,
   parameter int a = 8
) (
   input  logic         clk,
   input  logic         writeEnable,
   input  logic [a-1:0] index,
   input  logic [n-1:0] writeData,
   output logic [n-1:0] readData
);

   logic [n-1:0] r_words [0:(1<<a)-1];

   always_ff @(posedge clk) begin
      if (writeEnable) begin
         r_words[index] <= writeData;
      end
   end

   assign readData = r_words[index];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Memory-side responder for the datapath load/store port. Accepts
//            one word request at a time in IDLE, answers with a one-cycle
//            respValid pulse LATENCY cycles after acceptance.
// Ports    : clk          - system clock
//            reset        - asynchronous reset, active low
//            reqValid     - request present
//            reqWrite     - 1 = store, 0 = load
//            reqAddr      - byte address
//            reqWriteData - store data
//            reqReady     - responder idle, request can be accepted
//            respValid    - one-cycle response strobe
//            readData     - load result (0 for stores and errors)
//            respError    - misaligned or out-of-range request
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int n       = 32,
   parameter int a       = 8,
   parameter int LATENCY = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         reqValid,
   input  logic         reqWrite,
   input  logic [n-1:0] reqAddr,
   input  logic [n-1:0] reqWriteData,
   output logic         reqReady,
   output logic         respValid,
   output logic [n-1:0] readData,
   output logic         respError
);

   generate
      if (!latencyLegal(LATENCY)) begin : g_badLatency
         $error("data_mem_responder: LATENCY must be within 1..15");
      end
   endgenerate

   // Counter preload on entering WAIT; RESP follows once it reaches zero
   localparam logic [c_COUNT_W-1:0] c_WAIT_LOAD =
      (LATENCY > 1) ? c_COUNT_W'(LATENCY - 2) : '0;
   // With LATENCY 1 the accepting edge is also the edge entering RESP
   localparam bit c_DIRECT = (LATENCY == 1);

   respState_t           r_state;
   logic [c_COUNT_W-1:0] r_count;
   logic [n-1:0]         r_holdData;
   logic                 r_holdError;
   logic [n-1:0]         r_readData;
   logic                 r_respError;

   logic                 w_accept;
   logic                 w_misaligned;
   logic                 w_outOfRange;
   logic                 w_error;
   logic [n-1:0]         w_ramRead;
   logic [n-1:0]         w_loadValue;
   logic                 w_enterResp;

   assign w_accept     = (r_state == c_IDLE) && reqValid;
   assign w_misaligned = |reqAddr[1:0];

   generate
      if (a + 2 < n) begin : g_rangeCheck
         assign w_outOfRange = |reqAddr[n-1:a+2];
      end else begin : g_noRangeCheck
         assign w_outOfRange = 1'b0;
      end
   endgenerate

   assign w_error     = w_misaligned || w_outOfRange;
   // Stores and faulting loads always report zero data
   assign w_loadValue = (reqWrite || w_error) ? '0 : w_ramRead;
   assign w_enterResp = c_DIRECT ? w_accept
                                 : ((r_state == c_WAIT) && (r_count == '0));

   mem_word_array #(
      .n (n),
      .a (a)
   ) u_memWordArray (
      .clk         (clk),
      .writeEnable (w_accept && reqWrite && !w_error),
      .index       (reqAddr[a+1:2]),
      .writeData   (reqWriteData),
      .readData    (w_ramRead)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= c_IDLE;
         r_count     <= '0;
         r_holdData  <= '0;
         r_holdError <= 1'b0;
         r_readData  <= '0;
         r_respError <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (reqValid) begin
                  // Capture now: request inputs may change after acceptance
                  r_holdData  <= w_loadValue;
                  r_holdError <= w_error;
                  r_count     <= c_WAIT_LOAD;
                  r_state     <= c_DIRECT ? c_RESP : c_WAIT;
               end
            end
            c_WAIT: begin
               if (r_count == '0) begin
                  r_state <= c_RESP;
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
            c_RESP:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase

         if (w_enterResp) begin
            r_readData  <= c_DIRECT ? w_loadValue : r_holdData;
            r_respError <= c_DIRECT ? w_error     : r_holdError;
         end
      end
   end

   assign reqReady  = (r_state == c_IDLE);
   assign respValid = (r_state == c_RESP);
   assign readData  = r_readData;
   assign respError = r_respError;

endmodule
`default_nettype wire
